// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared selector encoding and default constants for the pc unit
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_REDIR,
    SEL_RET,
    SEL_ERET,
    SEL_TRAP
  } pc_sel_t;

  localparam int          DEF_STEP       = 4;
  localparam logic [31:0] DEF_RESET_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] DEF_TRAP_VEC   = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with saturating count and sticky error flags
module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int W         = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [W-1:0]  entries [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] count;

  // ptr names the next slot to write; when full that slot holds the oldest entry
  assign top_idx = ptr - 1'b1;
  assign top     = entries[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= top_idx;
        count <= count - 1'b1;
      end
    end else if (push) begin
      entries[ptr] <= push_data;
      ptr          <= ptr + 1'b1;
      if (full) overflow <= 1'b1;
      else      count    <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with priority next-pc select, epc and return-address stack
module pc_unit
  import pc_pkg::*;
#(
  parameter int           W          = 32,
  parameter int           STEP       = DEF_STEP,
  parameter logic [W-1:0] RESET_ADDR = {W{1'b1}} << 2,
  parameter logic [W-1:0] TRAP_VEC   = W'(DEF_TRAP_VEC),
  parameter int           RAS_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [W-1:0] redirect_addr,
  input  logic         call,
  input  logic         ret,
  input  logic         trap,
  input  logic         eret,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_next,
  output logic [W-1:0] epc,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_overflow,
  output logic         ras_underflow
);

  localparam logic [W-1:0] STEP_W     = W'(STEP);
  localparam logic [W-1:0] ALIGN_MASK = {W{1'b1}} << $clog2(STEP);

  pc_sel_t      sel;
  logic [W-1:0] pc_seq;
  logic [W-1:0] ras_top;
  logic         push;
  logic         pop;

  assign pc_seq = pc + STEP_W;

  always_comb begin
    sel = SEL_SEQ;
    if      (trap)           sel = SEL_TRAP;
    else if (stall)          sel = SEL_HOLD;
    else if (eret)           sel = SEL_ERET;
    else if (ret)            sel = SEL_RET;
    else if (redirect_valid) sel = SEL_REDIR;
  end

  // an empty-stack return falls through to the sequential address
  always_comb begin
    pc_next = pc_seq;
    case (sel)
      SEL_TRAP:  pc_next = TRAP_VEC;
      SEL_HOLD:  pc_next = pc;
      SEL_ERET:  pc_next = epc;
      SEL_RET:   pc_next = ras_empty ? pc_seq : ras_top;
      SEL_REDIR: pc_next = redirect_addr & ALIGN_MASK;
      default:   pc_next = pc_seq;
    endcase
  end

  assign push = (sel == SEL_REDIR) && call;
  assign pop  = (sel == SEL_RET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_ADDR;
      epc <= '0;
    end else begin
      pc <= pc_next;
      if (sel == SEL_TRAP) epc <= pc;
    end
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .W         (W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule
